// File: rtl/ram_access_arbiter.sv
// Clocked front end sharing one asynchronous mfa/mfc RAM between a fetch port and a data port.
// Define RAM_ARB_RR_EN for round-robin arbitration; fixed data-over-fetch priority otherwise.
module ram_access_arbiter #(
    parameter int ADDRESS_SIZE = 8,
    parameter int DATA_SIZE    = 32,
    parameter int TIMEOUT      = 15,
    parameter int TMO_W        = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_req,
    input  logic [ADDRESS_SIZE-1:0] i_addr,
    output logic                    i_ack,
    output logic [DATA_SIZE-1:0]    i_rdata,
    input  logic                    d_req,
    input  logic                    d_rw,
    input  logic [1:0]              d_mode,
    input  logic [ADDRESS_SIZE-1:0] d_addr,
    input  logic [DATA_SIZE-1:0]    d_wdata,
    output logic                    d_ack,
    output logic [DATA_SIZE-1:0]    d_rdata,
    output logic                    tmo_err,
    output logic                    busy,
    output logic                    mem_mfa,
    output logic                    mem_rw,
    output logic [1:0]              mem_mode,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_wdata,
    input  logic [DATA_SIZE-1:0]    mem_rdata,
    input  logic                    mem_mfc
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Timeout fires on the edge where the counter would reach TIMEOUT.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             mfc_meta;
    logic             mfc_s;
    logic [TMO_W-1:0] tmo_cnt;
    logic             owner_data;
    logic             grant_data;
    logic             grant_any;

    // A grant is refused while the RAM still reports completion of a previous access.
    assign grant_any = (d_req || i_req) && !mfc_s;
    assign busy      = (state != ST_IDLE);

`ifdef RAM_ARB_RR_EN
    logic last_data;

    // NOTE: always_comb gives grant_data a default first so no latch is inferred.
    always_comb begin
        grant_data = d_req;
        if (d_req && i_req) begin
            grant_data = !last_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_data <= 1'b0;
        end else if (state == ST_IDLE && grant_any) begin
            last_data <= grant_data;
        end
    end
`else
    assign grant_data = d_req;
`endif

    // NOTE: sequential state uses non-blocking assignments only, and the
    // reset is sampled on the clock edge rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            mfc_meta   <= 1'b0;
            mfc_s      <= 1'b0;
            tmo_cnt    <= '0;
            owner_data <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            tmo_err    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            mem_mfa    <= 1'b0;
            mem_rw     <= 1'b0;
            mem_mode   <= 2'b00;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            // NOTE: mem_mfc is asynchronous to clk; only mfc_s may feed logic.
            mfc_meta <= mem_mfc;
            mfc_s    <= mfc_meta;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            tmo_err  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner_data <= grant_data;
                        tmo_cnt    <= '0;
                        mem_mfa    <= 1'b1;
                        state      <= ST_REQ;
                        if (grant_data) begin
                            mem_rw    <= d_rw;
                            mem_mode  <= d_mode;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end else begin
                            mem_rw    <= 1'b0;
                            mem_mode  <= 2'b00;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                        end
                    end
                end

                ST_REQ: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (mfc_s) begin
                        if (owner_data) begin
                            d_ack <= 1'b1;
                            if (!mem_rw) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= mem_rdata;
                        end
                        mem_mfa <= 1'b0;
                        state   <= ST_RELEASE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Aborted access: acknowledge with the error flag, keep old read data.
                        d_ack   <= owner_data;
                        i_ack   <= !owner_data;
                        tmo_err <= 1'b1;
                        mem_mfa <= 1'b0;
                        state   <= ST_RELEASE;
                    end
                end

                ST_RELEASE: begin
                    if (!mfc_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    mem_mfa <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
